bus_lsu: RTL and testbench
==========================

// Module: bus_lsu
// PURPOSE
// - Parametrised load/store unit between CPU datapath and Bridge; successor to the single-cycle word-only Bus_* path.
// - Adds byte/half/word(/dword) access, byte enables, sign/zero extension, Bus_ready wait states, CPU stall and timeout/misalign errors.
// - Sits between the CPU's ALU/RF outputs and the Bridge; the CPU freezes PC/RF while lsu_stall=1.
// PARAMETERS
// - DATA_W   32   bus data width, 32 or 64; NB = DATA_W/8 byte lanes
// - ADDR_W   32   address width
// - TIMEOUT  255  max cycles waiting for Bus_ready; 0 = timeout disabled
// PORTS
// - cpu_clk       in   1       clock, all state on rising edge
// - cpu_rst       in   1       reset, asynchronous, active-high
// - lsu_req       in   1       access request, held by CPU until lsu_done
// - lsu_we        in   1       1 = store, 0 = load
// - lsu_size      in   2       0 byte, 1 half, 2 word, 3 dword (legal only if DATA_W=64)
// - lsu_unsigned  in   1       load zero-extends when 1, sign-extends when 0
// - lsu_addr      in   ADDR_W  byte address
// - lsu_wdata     in   DATA_W  store data, LSB-justified
// - lsu_rdata     out  DATA_W  extended load data, valid when lsu_done=1
// - lsu_done      out  1       1-cycle completion pulse
// - lsu_err       out  1       1-cycle pulse with lsu_done: misaligned/illegal size or timeout
// - lsu_stall     out  1       = lsu_req & ~lsu_done (combinational)
// - Bus_addr      out  ADDR_W  registered address, low log2(NB) bits forced to 0
// - Bus_req       out  1       registered bus request
// - Bus_wen       out  1       registered write enable, valid with Bus_req
// - Bus_be        out  NB      registered byte enables
// - Bus_wdata     out  DATA_W  registered lane-replicated store data
// - Bus_rdata     in   DATA_W  read data, sampled when Bus_req & Bus_ready
// - Bus_ready     in   1       slave completion; ignored unless Bus_req=1
// BEHAVIOUR
// - Reset: state IDLE; Bus_req, Bus_wen, Bus_be, lsu_done, lsu_err = 0; Bus_addr, Bus_wdata, lsu_rdata, timer = 0.
// - FSM IDLE -> REQ -> DONE -> IDLE; IDLE -> DONE directly on error.
// - IDLE: on lsu_req check (1<<lsu_size) <= NB and addr % (1<<size) == 0.
//   Fail: -> DONE with err=1, no bus cycle. Pass: latch addr/we/be/wdata/size/unsigned, -> REQ.
// - REQ: Bus_req=1; Bus_* stable until Bus_ready=1. Ready -> capture extended data into lsu_rdata, -> DONE.
//   Timer counts REQ cycles; reaching TIMEOUT without ready -> drop Bus_req, -> DONE with err=1, lsu_rdata=0.
// - DONE: lsu_done=1 (lsu_err per cause) for exactly one cycle -> IDLE. lsu_req seen in DONE is the completed access and is not re-accepted.
// - Latency: request accepted cycle t; Bus_req high t+1; Bus_ready at cycle r gives lsu_done at r+1. Min 2 cycles, 1 bus cycle.
// - Bus_be: byte = 1<<off; half = 2'b11<<off; word = 4'hF<<off; dword = all ones. off = addr[log2(NB)-1:0].
// - Bus_wdata: low (1<<size) bytes of lsu_wdata replicated across all lanes.
// - Load: Bus_rdata >> (8*off), keep (1<<size) bytes, extend per lsu_unsigned to DATA_W.
// - Bus_ready while IDLE/DONE ignored. Async reset mid-REQ: Bus_req drops immediately, access abandoned, no done pulse.
// - TIMEOUT=0: REQ waits indefinitely.
// STRUCTURE
// - defines.vh: size encodings (SZ_B/SZ_H/SZ_W/SZ_D), FSM state encodings, default TIMEOUT.
// - Sub-module lsu_align (combinational): be/wdata lane generation, load shift and extend, misalign check.
// - Top: FSM, timer, output registers.
// TESTING
// - sw addr 0x104, wdata 0xDEADBEEF, ready 1 cycle after Bus_req:
//   -> Bus_addr 0x104, be 4'hF, wen 1; done at t+2; err 0.
// - sb addr 0x203, wdata 0x000000A5:
//   -> be 4'b1000, Bus_wdata 0xA5A5A5A5.
// - lb addr 0x202 with Bus_rdata 0x0080_0000 -> lsu_rdata 0xFFFFFF80; lbu -> 0x00000080.
// - lh addr 0x101 -> no Bus_req; done+err at t+1.
// - TIMEOUT=4, Bus_ready held 0 -> Bus_req high 4 cycles, then done+err, lsu_rdata 0.
// - Assert cpu_rst mid-REQ -> Bus_req 0 same cycle, state IDLE, no done.
// - Bus_ready pulsed in IDLE -> no effect.
// - lsu_size 3 with DATA_W=32 -> done+err, no bus cycle.

Source files
------------

// File: rtl/bus_lsu_pkg.sv
// Shared encodings for the bus load/store unit: access sizes, FSM states,
// default wait-state timeout and a size-to-bytes helper.
package bus_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    // Number of bytes moved by an access of the given size encoding
    function automatic int size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 1;
            SZ_H:    return 2;
            SZ_W:    return 4;
            default: return 8;
        endcase
    endfunction

endpackage

// File: rtl/bus_lsu_align.sv
// Combinational lane logic for the load/store unit.
// Request side: byte enables, lane-replicated store data, legality check.
// Response side: shift the addressed bytes down and sign/zero extend.
module lsu_align
    import bus_lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NB     = DATA_W / 8,
    parameter int OW     = $clog2(DATA_W / 8)
) (
    input  logic [1:0]        i_size,
    input  logic [OW-1:0]     i_off,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [NB-1:0]     o_be,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_bad,
    input  logic [1:0]        i_ld_size,
    input  logic [OW-1:0]     i_ld_off,
    input  logic              i_ld_unsigned,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_rdata
);

    int                w_nb;
    int                w_off;
    int                w_ld_nb;
    logic [DATA_W-1:0] w_shift;
    logic              w_sign;

    // Request lanes: illegal when wider than the bus or not naturally aligned
    always_comb begin
        w_nb    = size_bytes(i_size);
        w_off   = int'(i_off);
        o_bad   = (w_nb > NB) || ((w_off % w_nb) != 0);
        o_be    = '0;
        o_wdata = '0;
        for (int i = 0; i < NB; i++) begin
            o_be[i]          = (i >= w_off) && (i < w_off + w_nb);
            o_wdata[8*i +: 8] = i_wdata[8*(i % w_nb) +: 8];
        end
    end

    // Load path: bring addressed bytes to lane 0, fill the rest with the extension bit
    always_comb begin
        w_shift = i_rdata >> {i_ld_off, 3'b000};
        w_ld_nb = size_bytes(i_ld_size);
        if (w_ld_nb > NB)
            w_ld_nb = NB;
        w_sign  = i_ld_unsigned ? 1'b0 : w_shift[8*w_ld_nb-1];
        o_rdata = '0;
        for (int i = 0; i < NB; i++)
            o_rdata[8*i +: 8] = (i < w_ld_nb) ? w_shift[8*i +: 8] : {8{w_sign}};
    end

endmodule

// File: rtl/bus_lsu.sv
// Load/store unit between the CPU datapath and the Bridge.
// Accepts one access at a time, runs one bus cycle with wait states and an
// optional timeout, and returns a single-cycle done (and err) pulse.
module bus_lsu
    import bus_lsu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rst,
    input  logic                   lsu_req,
    input  logic                   lsu_we,
    input  logic [1:0]             lsu_size,
    input  logic                   lsu_unsigned,
    input  logic [ADDR_W-1:0]      lsu_addr,
    input  logic [DATA_W-1:0]      lsu_wdata,
    output logic [DATA_W-1:0]      lsu_rdata,
    output logic                   lsu_done,
    output logic                   lsu_err,
    output logic                   lsu_stall,
    output logic [ADDR_W-1:0]      Bus_addr,
    output logic                   Bus_req,
    output logic                   Bus_wen,
    output logic [DATA_W/8-1:0]    Bus_be,
    output logic [DATA_W-1:0]      Bus_wdata,
    input  logic [DATA_W-1:0]      Bus_rdata,
    input  logic                   Bus_ready
);

    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    lsu_state_t        r_state;
    logic [TW-1:0]     r_timer;
    logic [1:0]        r_ld_size;
    logic [OW-1:0]     r_ld_off;
    logic              r_ld_unsigned;

    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_wdata;
    logic              w_bad;
    logic [DATA_W-1:0] w_ld_rdata;
    logic              w_tmo;

    lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_size        (lsu_size),
        .i_off         (lsu_addr[OW-1:0]),
        .i_wdata       (lsu_wdata),
        .o_be          (w_be),
        .o_wdata       (w_wdata),
        .o_bad         (w_bad),
        .i_ld_size     (r_ld_size),
        .i_ld_off      (r_ld_off),
        .i_ld_unsigned (r_ld_unsigned),
        .i_rdata       (Bus_rdata),
        .o_rdata       (w_ld_rdata)
    );

    // Last permitted wait cycle; never fires when the timeout is disabled
    assign w_tmo     = (TIMEOUT != 0) && (r_timer == TMO_LAST);
    // CPU freezes until the completion pulse
    assign lsu_stall = lsu_req & ~lsu_done;

    // Access FSM with registered bus and completion outputs
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_ld_size     <= SZ_B;
            r_ld_off      <= '0;
            r_ld_unsigned <= 1'b0;
            Bus_req       <= 1'b0;
            Bus_wen       <= 1'b0;
            Bus_be        <= '0;
            Bus_addr      <= '0;
            Bus_wdata     <= '0;
            lsu_rdata     <= '0;
            lsu_done      <= 1'b0;
            lsu_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    lsu_done <= 1'b0;
                    lsu_err  <= 1'b0;
                    if (lsu_req) begin
                        if (w_bad) begin
                            // Misaligned or too wide: complete with error, no bus cycle
                            lsu_rdata <= '0;
                            lsu_done  <= 1'b1;
                            lsu_err   <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            Bus_req       <= 1'b1;
                            Bus_wen       <= lsu_we;
                            Bus_be        <= w_be;
                            Bus_wdata     <= w_wdata;
                            Bus_addr      <= {lsu_addr[ADDR_W-1:OW], {OW{1'b0}}};
                            r_ld_size     <= lsu_size;
                            r_ld_off      <= lsu_addr[OW-1:0];
                            r_ld_unsigned <= lsu_unsigned;
                            r_timer       <= '0;
                            r_state       <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (Bus_ready) begin
                        Bus_req   <= 1'b0;
                        Bus_wen   <= 1'b0;
                        Bus_be    <= '0;
                        lsu_rdata <= w_ld_rdata;
                        lsu_done  <= 1'b1;
                        r_state   <= ST_DONE;
                    end else if (w_tmo) begin
                        Bus_req   <= 1'b0;
                        Bus_wen   <= 1'b0;
                        Bus_be    <= '0;
                        lsu_rdata <= '0;
                        lsu_done  <= 1'b1;
                        lsu_err   <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_DONE: begin
                    // The held request belongs to the access just completed
                    lsu_done <= 1'b0;
                    lsu_err  <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_lsu.sv
// Bench for bus_lsu (DATA_W=32, TIMEOUT=4): table of accesses with a
// scoreboard of expected completions, plus reset/idle corner sequences.
module tb_bus_lsu;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        lsu_req;
    logic        lsu_we;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_done;
    logic        lsu_err;
    logic        lsu_stall;
    logic [31:0] Bus_addr;
    logic        Bus_req;
    logic        Bus_wen;
    logic [3:0]  Bus_be;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;
    logic        Bus_ready;

    int n_chk  = 0;
    int n_fail = 0;

    bus_lsu #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .TIMEOUT (4)
    ) dut (
        .cpu_clk      (cpu_clk),
        .cpu_rst      (cpu_rst),
        .lsu_req      (lsu_req),
        .lsu_we       (lsu_we),
        .lsu_size     (lsu_size),
        .lsu_unsigned (lsu_unsigned),
        .lsu_addr     (lsu_addr),
        .lsu_wdata    (lsu_wdata),
        .lsu_rdata    (lsu_rdata),
        .lsu_done     (lsu_done),
        .lsu_err      (lsu_err),
        .lsu_stall    (lsu_stall),
        .Bus_addr     (Bus_addr),
        .Bus_req      (Bus_req),
        .Bus_wen      (Bus_wen),
        .Bus_be       (Bus_be),
        .Bus_wdata    (Bus_wdata),
        .Bus_rdata    (Bus_rdata),
        .Bus_ready    (Bus_ready)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brdata;
        int          delay;    // Bus_req cycles before ready (large = never)
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        chk_rd;
        logic        e_err;
        int          e_bcyc;   // expected number of Bus_req cycles
        int          e_lat;    // cycles from acceptance to done
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
        int          lat;
        int          bcyc;
    } exp_t;

    vec_t vecs[14];
    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got_e;
        int   cyc;
        int   req_cyc;
        bit   got;
        e.rdata  = v.e_rdata;
        e.err    = v.e_err;
        e.chk_rd = v.chk_rd;
        e.lat    = v.e_lat;
        e.bcyc   = v.e_bcyc;
        exp_q.push_back(e);
        @(negedge cpu_clk);
        lsu_req      = 1'b1;
        lsu_we       = v.we;
        lsu_size     = v.size;
        lsu_unsigned = v.uns;
        lsu_addr     = v.addr;
        lsu_wdata    = v.wdata;
        Bus_rdata    = v.brdata;
        cyc     = 0;
        req_cyc = 0;
        got     = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge cpu_clk);
            cyc++;
            if (lsu_done) begin
                got   = 1'b1;
                got_e = exp_q.pop_front();
                chk("err", lsu_err, got_e.err);
                if (got_e.chk_rd)
                    chk("rdata", lsu_rdata, got_e.rdata);
                chk("latency", cyc, got_e.lat);
                chk("bus_cycles", req_cyc, got_e.bcyc);
                chk("stall_at_done", lsu_stall, 1'b0);
            end else begin
                if (cyc == 1)
                    chk("stall_pending", lsu_stall, 1'b1);
                if (Bus_req) begin
                    if (req_cyc == 0) begin
                        chk("bus_addr", Bus_addr, v.e_addr);
                        chk("bus_be", Bus_be, v.e_be);
                        chk("bus_wen", Bus_wen, v.we);
                        if (v.we)
                            chk("bus_wdata", Bus_wdata, v.e_wdata);
                    end
                    Bus_ready = (req_cyc == v.delay);
                    req_cyc++;
                end else begin
                    Bus_ready = 1'b0;
                end
            end
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_wait: no lsu_done within %0d cycles, expected at %0d", cyc, v.e_lat);
            if (exp_q.size() > 0)
                void'(exp_q.pop_front());
        end
        Bus_ready = 1'b0;
        // Keep the request up across the DONE cycle edge; it must not start a new access
        @(posedge cpu_clk);
        #1 lsu_req = 1'b0;
        @(negedge cpu_clk);
        chk("no_reaccept_req", Bus_req, 1'b0);
        chk("no_reaccept_done", lsu_done, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        //         we    sz    uns   addr          wdata         brdata        dly e_addr        be      e_wdata       e_rdata       chk   err  bc  lat
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        0,  32'h0000_0104, 4'hF,   32'hDEAD_BEEF, 32'h0,        1'b0, 1'b0, 1, 2};
        vecs[1]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0203, 32'h0000_00A5, 32'h0,        0,  32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'h0,       1'b0, 1'b0, 1, 2};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0202, 32'h0,        32'h0080_0000, 1,  32'h0000_0200, 4'b0100, 32'h0,        32'hFFFF_FF80, 1'b1, 1'b0, 2, 3};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0202, 32'h0,        32'h0080_0000, 0,  32'h0000_0200, 4'b0100, 32'h0,        32'h0000_0080, 1'b1, 1'b0, 1, 2};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0101, 32'h0,        32'h0,        0,  32'h0,        4'h0,   32'h0,        32'h0,        1'b0, 1'b1, 0, 1};
        vecs[5]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        0,  32'h0,        4'h0,   32'h0,        32'h0,        1'b0, 1'b1, 0, 1};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0,        32'h8001_1234, 2,  32'h0000_0100, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b1, 1'b0, 3, 4};
        vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0100, 32'h0,        32'h1234_F00D, 0,  32'h0000_0100, 4'b0011, 32'h0,        32'h0000_F00D, 1'b1, 1'b0, 1, 2};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0208, 32'h0,        32'hCAFE_BABE, 1,  32'h0000_0208, 4'hF,   32'h0,        32'hCAFE_BABE, 1'b1, 1'b0, 2, 3};
        vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0106, 32'h1234_BEEF, 32'h0,        0,  32'h0000_0104, 4'b1100, 32'hBEEF_BEEF, 32'h0,       1'b0, 1'b0, 1, 2};
        vecs[10] = '{1'b0, 2'd0, 1'b0, 32'h0000_0201, 32'h0,        32'h0000_7F00, 0,  32'h0000_0200, 4'b0010, 32'h0,        32'h0000_007F, 1'b1, 1'b0, 1, 2};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0,        32'h5555_5555, 99, 32'h0000_0300, 4'hF,   32'h0,        32'h0,        1'b1, 1'b1, 4, 5};
        vecs[12] = '{1'b1, 2'd2, 1'b0, 32'h0000_0102, 32'h1111_2222, 32'h0,        0,  32'h0,        4'h0,   32'h0,        32'h0,        1'b0, 1'b1, 0, 1};
        vecs[13] = '{1'b1, 2'd0, 1'b0, 32'h0000_0007, 32'h1234_5601, 32'h0,        0,  32'h0000_0004, 4'b1000, 32'h0101_0101, 32'h0,       1'b0, 1'b0, 1, 2};

        cpu_rst      = 1'b1;
        lsu_req      = 1'b0;
        lsu_we       = 1'b0;
        lsu_size     = 2'd0;
        lsu_unsigned = 1'b0;
        lsu_addr     = '0;
        lsu_wdata    = '0;
        Bus_rdata    = '0;
        Bus_ready    = 1'b0;

        // Reset state
        repeat (2) @(negedge cpu_clk);
        chk("rst_bus_req", Bus_req, 1'b0);
        chk("rst_bus_wen", Bus_wen, 1'b0);
        chk("rst_bus_be", Bus_be, 4'h0);
        chk("rst_bus_addr", Bus_addr, 32'h0);
        chk("rst_bus_wdata", Bus_wdata, 32'h0);
        chk("rst_done", lsu_done, 1'b0);
        chk("rst_err", lsu_err, 1'b0);
        chk("rst_rdata", lsu_rdata, 32'h0);
        cpu_rst = 1'b0;
        @(negedge cpu_clk);

        // Table of accesses
        for (int i = 0; i < 14; i++)
            run_vec(vecs[i]);

        // Bus_ready while idle has no effect
        Bus_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge cpu_clk);
            chk("idle_ready_req", Bus_req, 1'b0);
            chk("idle_ready_done", lsu_done, 1'b0);
        end
        Bus_ready = 1'b0;

        // Async reset in the middle of a bus cycle
        @(negedge cpu_clk);
        lsu_req  = 1'b1;
        lsu_we   = 1'b0;
        lsu_size = 2'd2;
        lsu_addr = 32'h0000_0400;
        @(negedge cpu_clk);
        chk("pre_rst_bus_req", Bus_req, 1'b1);
        #2 cpu_rst = 1'b1;
        #1;
        chk("rst_mid_req_drop", Bus_req, 1'b0);
        chk("rst_mid_req_done", lsu_done, 1'b0);
        lsu_req = 1'b0;
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge cpu_clk);
            chk("post_rst_done", lsu_done, 1'b0);
            chk("post_rst_req", Bus_req, 1'b0);
        end

        // Unit is back in IDLE and serves a normal access
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
